// File: rtl/rvm_mem_if_pkg.sv
// rvm_mem_if_pkg: access size and sequencer state encodings shared by the memory interface.
package rvm_mem_if_pkg;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } memif_state_e;
endpackage

// File: rtl/rvm_mem_align.sv
// rvm_mem_align: byte-lane steering for stores, load extraction/extension and alignment check.
module rvm_mem_align
    import rvm_mem_if_pkg::*;
(
    input  logic [1:0]  chk_size,
    input  logic [1:0]  chk_addr,
    output logic        misaligned,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    always_comb begin
        misaligned = (chk_size == 2'b11) || (chk_size == SIZE_H && chk_addr[0]) || (chk_size == SIZE_W && chk_addr != 2'b00);
        lane_byte  = rdata[{addr, 3'b000} +: 8];
        lane_half  = addr[1] ? rdata[31:16] : rdata[15:0];
        strb       = size == SIZE_B ? 4'b0001 << addr : size == SIZE_H ? 4'b0011 << addr : 4'b1111;
        wdata_rep  = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
        rdata_ext  = size == SIZE_B ? {{24{sign & lane_byte[7]}}, lane_byte}
                   : size == SIZE_H ? {{16{sign & lane_half[15]}}, lane_half} : rdata;
    end
endmodule

// File: rtl/rvm_mem_if.sv
// rvm_mem_if: sequences one aligned load/store from the control FSM over a gnt/rvalid memory bus.
module rvm_mem_if
    import rvm_mem_if_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        ctrl_req,
    input  logic        ctrl_wen,
    input  logic [1:0]  ctrl_size,
    input  logic        ctrl_sign,
    input  logic [31:0] ctrl_addr,
    input  logic [31:0] ctrl_wdata,
    output logic        ctrl_done,
    output logic        ctrl_error,
    output logic [31:0] ctrl_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [3:0]  mem_strb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err
);
    memif_state_e state_q, state_d;
    logic        wen_q, wen_d, sign_q, sign_d, err_q, err_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        misaligned;
    logic [3:0]  strb;
    logic [31:0] wdata_rep, rdata_ext;

    rvm_mem_align u_align (
        .chk_size   (ctrl_size),
        .chk_addr   (ctrl_addr[1:0]),
        .misaligned (misaligned),
        .size       (size_q),
        .sign       (sign_q),
        .addr       (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (mem_rdata),
        .strb       (strb),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext)
    );

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (ctrl_req) begin
                wen_d   = ctrl_wen;
                size_d  = ctrl_size;
                sign_d  = ctrl_sign;
                addr_d  = ctrl_addr;
                wdata_d = ctrl_wdata;
                err_d   = misaligned;
                state_d = misaligned ? DONE : ADDR;
            end
            ADDR: state_d = mem_gnt ? RESP : ADDR;
            RESP: if (mem_rvalid) begin
                state_d = DONE;
                err_d   = mem_err;
                rdata_d = (!wen_q && !mem_err) ? rdata_ext : rdata_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            size_q  <= SIZE_B;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus and control outputs come only from registered request fields and state.
    assign mem_req    = state_q == ADDR;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wen    = wen_q;
    assign mem_strb   = wen_q ? strb : 4'b0000;
    assign mem_wdata  = wdata_rep;
    assign ctrl_done  = state_q == DONE;
    assign ctrl_error = state_q == DONE && err_q;
    assign ctrl_rdata = rdata_q;
endmodule

// File: tb/tb_rvm_mem_if.sv
// tb_rvm_mem_if: directed vectors for rvm_mem_if with hand-computed expected values.
module tb_rvm_mem_if;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_req = 1'b0, ctrl_wen = 1'b0, ctrl_sign = 1'b0;
    logic [1:0]  ctrl_size = 2'b00;
    logic [31:0] ctrl_addr = '0, ctrl_wdata = '0;
    logic        ctrl_done, ctrl_error, mem_req, mem_wen;
    logic [31:0] ctrl_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_strb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = '0;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    rvm_mem_if dut (
        .clk(clk), .resetn(resetn),
        .ctrl_req(ctrl_req), .ctrl_wen(ctrl_wen), .ctrl_size(ctrl_size), .ctrl_sign(ctrl_sign),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata),
        .ctrl_done(ctrl_done), .ctrl_error(ctrl_error), .ctrl_rdata(ctrl_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a request, stalls grant gdly cycles, answers one cycle later; returns in the DONE cycle.
    task automatic run(input string tag, input logic wen, input logic [1:0] size, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err, input int gdly, input logic [31:0] e_addr,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata);
        ctrl_req = 1'b1; ctrl_wen = wen; ctrl_size = size; ctrl_sign = sign;
        ctrl_addr = addr; ctrl_wdata = wdata;
        step();
        ctrl_req = 1'b0; ctrl_addr = 32'hFFFF_FFFF; ctrl_wdata = 32'h0; ctrl_size = 2'b11;
        for (int i = 0; i <= gdly; i++) begin
            check({tag, ".req"}, {31'd0, mem_req}, 32'd1);
            check({tag, ".addr"}, mem_addr, e_addr);
            if (i == gdly) begin
                check({tag, ".wen"}, {31'd0, mem_wen}, {31'd0, wen});
                check({tag, ".strb"}, {28'd0, mem_strb}, {28'd0, e_strb});
                if (wen) check({tag, ".wdata"}, mem_wdata, e_wdata);
                mem_gnt = 1'b1;
            end
            step();
        end
        mem_gnt = 1'b0;
        check({tag, ".req_low"}, {31'd0, mem_req}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
        step();
        mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = 32'h0;
        check({tag, ".done"}, {31'd0, ctrl_done}, 32'd1);
    endtask

    task automatic finish_access(input string tag, input logic e_err, input logic [31:0] e_rdata);
        check({tag, ".err"}, {31'd0, ctrl_error}, {31'd0, e_err});
        check({tag, ".rdata"}, ctrl_rdata, e_rdata);
        step();
        check({tag, ".done_pulse"}, {31'd0, ctrl_done}, 32'd0);
    endtask

    initial begin
        step();
        check("rst.done", {31'd0, ctrl_done}, 32'd0);
        check("rst.err", {31'd0, ctrl_error}, 32'd0);
        check("rst.req", {31'd0, mem_req}, 32'd0);
        check("rst.wen", {31'd0, mem_wen}, 32'd0);
        check("rst.strb", {28'd0, mem_strb}, 32'd0);
        check("rst.addr", mem_addr, 32'd0);
        check("rst.wdata", mem_wdata, 32'd0);
        check("rst.rdata", ctrl_rdata, 32'd0);
        resetn = 1'b1;
        step();

        run("lw", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        finish_access("lw", 1'b0, 32'hDEADBEEF);
        run("lb", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80123456, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        finish_access("lb", 1'b0, 32'hFFFFFF80);
        run("lbu", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80123456, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        finish_access("lbu", 1'b0, 32'h00000080);
        run("lbu1", 1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 32'h80123456, 1'b0, 1, 32'h100, 4'b0000, 32'h0);
        finish_access("lbu1", 1'b0, 32'h00000034);
        run("lh", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h80123456, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        finish_access("lh", 1'b0, 32'hFFFF8012);
        run("lhu", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80123456, 1'b0, 0, 32'h100, 4'b0000, 32'h0);
        finish_access("lhu", 1'b0, 32'h00008012);

        run("sh", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD, 32'h0, 1'b0, 3, 32'h100, 4'b1100, 32'hABCDABCD);
        finish_access("sh", 1'b0, 32'h00008012);
        run("sb", 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A, 32'h0, 1'b0, 0, 32'h200, 4'b0010, 32'h5A5A5A5A);
        finish_access("sb", 1'b0, 32'h00008012);
        run("sw", 1'b1, 2'b10, 1'b0, 32'h104, 32'h12345678, 32'h0, 1'b0, 2, 32'h104, 4'b1111, 32'h12345678);
        finish_access("sw", 1'b0, 32'h00008012);

        ctrl_req = 1'b1; ctrl_wen = 1'b0; ctrl_size = 2'b10; ctrl_sign = 1'b0; ctrl_addr = 32'h101;
        step();
        ctrl_req = 1'b0;
        check("mis.req", {31'd0, mem_req}, 32'd0);
        check("mis.done", {31'd0, ctrl_done}, 32'd1);
        finish_access("mis", 1'b1, 32'h00008012);
        check("mis.req2", {31'd0, mem_req}, 32'd0);

        ctrl_req = 1'b1; ctrl_size = 2'b01; ctrl_addr = 32'h303;
        step();
        ctrl_req = 1'b0;
        check("mish.done", {31'd0, ctrl_done}, 32'd1);
        finish_access("mish", 1'b1, 32'h00008012);

        ctrl_req = 1'b1; ctrl_size = 2'b11; ctrl_addr = 32'h100;
        step();
        ctrl_req = 1'b0;
        check("ill.done", {31'd0, ctrl_done}, 32'd1);
        finish_access("ill", 1'b1, 32'h00008012);

        run("berr", 1'b0, 2'b10, 1'b0, 32'h108, 32'h0, 32'h11111111, 1'b1, 0, 32'h108, 4'b0000, 32'h0);
        finish_access("berr", 1'b1, 32'h00008012);

        ctrl_req = 1'b1; ctrl_size = 2'b10; ctrl_addr = 32'h200;
        step();
        ctrl_req = 1'b0;
        check("rsta.req_hi", {31'd0, mem_req}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rsta.req_drop", {31'd0, mem_req}, 32'd0);
        check("rsta.rdata", ctrl_rdata, 32'd0);
        step();
        resetn = 1'b1;
        step();

        ctrl_req = 1'b1; ctrl_size = 2'b10; ctrl_addr = 32'h204;
        step();
        ctrl_req = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        resetn = 1'b0;
        #1;
        check("rstr.req", {31'd0, mem_req}, 32'd0);
        step();
        resetn = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rstr.no_done", {31'd0, ctrl_done}, 32'd0);
            check("rstr.no_req", {31'd0, mem_req}, 32'd0);
            step();
        end
        check("rstr.rdata", ctrl_rdata, 32'd0);

        run("post", 1'b0, 2'b10, 1'b0, 32'h10C, 32'h0, 32'h0BADF00D, 1'b0, 0, 32'h10C, 4'b0000, 32'h0);
        finish_access("post", 1'b0, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
